// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and width helpers for the cache-line <-> memory-burst adaptor.
package cacheline_burst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_e;

  function automatic int unsigned beats_of(input int unsigned line_w, input int unsigned bus_w);
    return line_w / bus_w;
  endfunction

  function automatic int unsigned beat_idx_w(input int unsigned line_w, input int unsigned bus_w);
    return (beats_of(line_w, bus_w) > 2) ? $clog2(beats_of(line_w, bus_w)) : 1;
  endfunction

  function automatic int unsigned line_ofs_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int unsigned word_ofs_w(input int unsigned bus_w);
    return $clog2(bus_w / 8);
  endfunction

  // Default geometry of the original fixed 256/32 adaptor.
  localparam int unsigned DEF_LINE_W = 256;
  localparam int unsigned DEF_BUS_W  = 32;
  localparam int unsigned BEATS      = beats_of(DEF_LINE_W, DEF_BUS_W);
  localparam int unsigned BEAT_IDX_W = beat_idx_w(DEF_LINE_W, DEF_BUS_W);
  localparam int unsigned LINE_OFS_W = line_ofs_w(DEF_LINE_W);
  localparam int unsigned WORD_OFS_W = word_ofs_w(DEF_BUS_W);

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Burst-side memory bus: master is the adaptor, slave is physical memory.
interface cacheline_burst_adaptor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BUS_W  = 32
) ();
  logic [ADDR_W-1:0] burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BUS_W-1:0]  burst_wdata;
  logic [BUS_W-1:0]  burst_rdata;
  logic              burst_resp;

  modport master (
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport slave (
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/cacheline_burst_adaptor_beat_sequencer.sv
// Beat slot index (wraps modulo BEATS from a loadable start) plus beat count for last-beat detection.
module beat_sequencer #(
  parameter int unsigned BEATS = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             MEM_CLK,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             advance,
  output logic [IDX_W-1:0] beat_idx,
  output logic             last_beat
);
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] count_q;

  // Slot index and beat count are kept apart so a wrapped start still ends after BEATS beats.
  always_ff @(posedge MEM_CLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      count_q <= '0;
    end else if (load) begin
      idx_q   <= start_idx;
      count_q <= '0;
    end else if (advance) begin
      idx_q   <= idx_q + IDX_W'(1);
      count_q <= count_q + IDX_W'(1);
    end
  end

  assign beat_idx  = idx_q;
  assign last_beat = (count_q == IDX_W'(BEATS - 1));
endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Cache line <-> memory burst adaptor; define CACHELINE_BURST_CWF_EN for critical-word-first ordering.
module cacheline_burst_adaptor
  import cacheline_burst_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       MEM_CLK,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          line_address,
  input  logic                       line_read,
  input  logic                       line_write,
  input  logic [LINE_W-1:0]          line_wdata,
  output logic [LINE_W-1:0]          line_rdata,
  output logic                       line_resp,
  cacheline_burst_adaptor_if.master  mem,
  output logic                       proto_err
);
  localparam int unsigned NBEATS  = beats_of(LINE_W, BUS_W);
  localparam int unsigned IDX_W   = beat_idx_w(LINE_W, BUS_W);
  localparam int unsigned LOFS_W  = line_ofs_w(LINE_W);
  localparam int unsigned WOFS_W  = word_ofs_w(BUS_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LOFS_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~((ADDR_W'(1) << WOFS_W) - ADDR_W'(1));

  if ((LINE_W % BUS_W) != 0 || NBEATS < 2) begin : g_bad_ratio
    $error("LINE_W must be a multiple of BUS_W with at least two beats");
  end
  if ((NBEATS & (NBEATS - 1)) != 0 || BUS_W < 8 || (BUS_W & (BUS_W - 1)) != 0) begin : g_bad_pow2
    $error("BUS_W and LINE_W/BUS_W must be powers of two, BUS_W >= 8");
  end

  burst_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   req_addr;
  logic [LINE_W-1:0]   line_buf_q;
  logic [LINE_W-1:0]   line_merge;
  logic [LINE_W-1:0]   line_rdata_q;
  logic                proto_err_q;
  logic                take_rd, take_wr;
  logic                beat_adv, beat_last;
  logic [IDX_W-1:0]    beat_idx, start_idx;
  logic [31:0]         slot_lsb;

`ifdef CACHELINE_BURST_CWF_EN
  assign req_addr  = line_address & WORD_MASK;
  assign start_idx = line_address[LOFS_W-1:WOFS_W];
`else
  assign req_addr  = line_address & LINE_MASK;
  assign start_idx = '0;
`endif

  beat_sequencer #(
    .BEATS (NBEATS),
    .IDX_W (IDX_W)
  ) u_seq (
    .MEM_CLK   (MEM_CLK),
    .rst_n     (rst_n),
    .load      (take_rd | take_wr),
    .start_idx (start_idx),
    .advance   (beat_adv),
    .beat_idx  (beat_idx),
    .last_beat (beat_last)
  );

  // burst_resp only counts while a burst is actually in flight.
  assign beat_adv = mem.burst_resp && (state_q == RD_BURST || state_q == WR_BURST);
  assign slot_lsb = 32'(beat_idx) * BUS_W;

  always_comb begin
    state_d = state_q;
    take_rd = 1'b0;
    take_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          take_wr = 1'b1;
          state_d = WR_BURST;
        end else if (line_read) begin
          take_rd = 1'b1;
          state_d = RD_BURST;
        end
      end
      RD_BURST, WR_BURST: if (beat_adv && beat_last) state_d = DONE;
      DONE:               state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    line_merge = line_buf_q;
    line_merge[slot_lsb +: BUS_W] = mem.burst_rdata;
  end

  always_ff @(posedge MEM_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_rd || take_wr) addr_q <= req_addr;
      if (take_wr && line_read) proto_err_q <= 1'b1;
    end
  end

  // Beats assemble in line_buf_q; line_rdata only changes when a read finishes.
  always_ff @(posedge MEM_CLK or negedge rst_n) begin
    if (!rst_n) begin
      line_buf_q   <= '0;
      line_rdata_q <= '0;
    end else if (take_wr) begin
      line_buf_q <= line_wdata;
    end else if (state_q == RD_BURST && beat_adv) begin
      line_buf_q <= line_merge;
      if (beat_last) line_rdata_q <= line_merge;
    end
  end

  assign mem.burst_address = addr_q;
  assign mem.burst_read    = (state_q == RD_BURST);
  assign mem.burst_write   = (state_q == WR_BURST);
  assign mem.burst_wdata   = (state_q == WR_BURST) ? line_buf_q[slot_lsb +: BUS_W] : '0;
  assign line_resp         = (state_q == DONE);
  assign line_rdata        = line_rdata_q;
  assign proto_err         = proto_err_q;
endmodule
